// File: rtl/bcd_converter_pkg.sv
// Shared definitions for the binary-to-BCD converter: state encoding,
// digit width and the digit-count sizing rule.
package bcd_converter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    // Smallest digit count d such that 10^d > 2^n, i.e. every n-bit value fits.
    function automatic int min_digits(input int n);
        longint unsigned pow2;
        longint unsigned pow10;
        int              d;
        pow2  = 64'd1 << n;
        pow10 = 64'd1;
        d     = 0;
        while (pow10 <= pow2) begin
            pow10 = pow10 * 64'd10;
            d     = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_converter_digit_adjust.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
    import bcd_converter_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter: one bit per clock,
// fixed N-cycle conversion, start/finished pulse handshake.
module bcd_converter
    import bcd_converter_pkg::*;
#(
    parameter int N      = 8,
    parameter int DIGITS = 3
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic                            i_start,
    input  logic [N-1:0]                    i_binary,
    output logic                            o_busy,
    output logic                            o_finished,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   o_bcd
);

    localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
    localparam int WORK_W = BCD_W + N;
    localparam int CNT_W  = $clog2(N + 1);

    if (DIGITS < min_digits(N)) begin : g_digits_check
        $error("bcd_converter: DIGITS too small to hold every N-bit value");
    end

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   count;
    // {scratch, binary}: BCD digits on top, unconverted bits below.
    logic [WORK_W-1:0]  work;
    logic [WORK_W-1:0]  work_adj;
    logic [WORK_W-1:0]  shifted;
    logic [BCD_W-1:0]   adjusted;
    logic               accept;
    logic               last_shift;

    for (genvar d = 0; d < DIGITS; d++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .digit    (work[N + BCD_DIGIT_W*d +: BCD_DIGIT_W]),
            .adjusted (adjusted[BCD_DIGIT_W*d +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        work_adj   = {adjusted, work[N-1:0]};
        shifted    = work_adj << 1;
        accept     = i_start && ((state == IDLE) || (state == DONE));
        last_shift = (state == SHIFT) && (count == CNT_W'(1));
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (i_start) next_state = SHIFT;
            SHIFT:   if (count == CNT_W'(1)) next_state = DONE;
            DONE:    next_state = i_start ? SHIFT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        o_busy     = (state == SHIFT);
        o_finished = (state == DONE);
    end

    // o_bcd is a holding register: only the final shift of a conversion updates it.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count <= '0;
            work  <= '0;
            o_bcd <= '0;
        end else if (accept) begin
            count <= CNT_W'(N);
            work  <= {{BCD_W{1'b0}}, i_binary};
        end else if (state == SHIFT) begin
            count <= count - CNT_W'(1);
            work  <= shifted;
            if (last_shift) begin
                o_bcd <= shifted[WORK_W-1:N];
            end
        end
    end

endmodule

// File: tb/tb_bcd_converter.sv
// Self-checking bench for bcd_converter: N=8 and N=16 instances, directed
// corner cases plus random values checked against a decimal reference model.
module tb_bcd_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [7:0]  bin8;
    logic [15:0] bin16;
    logic        busy8, busy16, fin8, fin16;
    logic [11:0] bcd8;
    logic [19:0] bcd16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_converter #(.N(8), .DIGITS(3)) u_dut8 (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_start    (start8),
        .i_binary   (bin8),
        .o_busy     (busy8),
        .o_finished (fin8),
        .o_bcd      (bcd8)
    );

    bcd_converter #(.N(16), .DIGITS(5)) u_dut16 (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_start    (start16),
        .i_binary   (bin16),
        .o_busy     (busy16),
        .o_finished (fin16),
        .o_bcd      (bcd16)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits by repeated division, packed 4 bits per digit.
    function automatic logic [31:0] to_bcd(input int unsigned value);
        logic [31:0] r;
        int unsigned v;
        r = '0;
        v = value;
        for (int i = 0; i < 8; i++) begin
            r = r | (32'(v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bcd_of(input bit wide);
        return wide ? {12'b0, bcd16} : {20'b0, bcd8};
    endfunction

    task automatic drive_start(input bit wide, input int unsigned value);
        if (wide) begin
            start16 = 1'b1;
            bin16   = value[15:0];
        end else begin
            start8 = 1'b1;
            bin8   = value[7:0];
        end
        tick();
        start8  = 1'b0;
        start16 = 1'b0;
        bin8    = 8'($urandom);
        bin16   = 16'($urandom);
    endtask

    // Waits (bounded) for o_finished; returns cycles waited and busy cycles seen.
    task automatic wait_finish(input bit wide, input int n, output int cyc, output int busy_cnt);
        cyc      = 0;
        busy_cnt = 0;
        while (!(wide ? fin16 : fin8) && cyc < 4 * n) begin
            if (wide ? busy16 : busy8) busy_cnt++;
            tick();
            cyc++;
        end
    endtask

    task automatic convert(input bit wide, input int unsigned value, input string tag);
        int n, cyc, busy_cnt;
        n = wide ? 16 : 8;
        drive_start(wide, value);
        wait_finish(wide, n, cyc, busy_cnt);
        check_eq({tag, "_latency"}, cyc, n);
        check_eq({tag, "_busy_cycles"}, busy_cnt, n);
        check_eq({tag, "_bcd"}, bcd_of(wide), to_bcd(value));
        check_eq({tag, "_busy_in_done"}, 32'(wide ? busy16 : busy8), 0);
        tick();
        check_eq({tag, "_fin_one_cycle"}, 32'(wide ? fin16 : fin8), 0);
        check_eq({tag, "_bcd_hold"}, bcd_of(wide), to_bcd(value));
    endtask

    initial begin
        int cyc, busy_cnt, pulses;
        rst = 1'b1; start8 = 1'b0; start16 = 1'b0; bin8 = '0; bin16 = '0;
        tick();
        tick();
        check_eq("reset_busy8", 32'(busy8), 0);
        check_eq("reset_fin8", 32'(fin8), 0);
        check_eq("reset_bcd8", bcd_of(1'b0), 0);
        check_eq("reset_bcd16", bcd_of(1'b1), 0);
        rst = 1'b0;
        tick();

        convert(1'b0, 255, "c255");
        convert(1'b0, 0, "c0");
        convert(1'b0, 99, "c99");
        convert(1'b0, 100, "c100");

        // Start during SHIFT must be ignored.
        drive_start(1'b0, 37);
        tick();
        tick();
        start8 = 1'b1; bin8 = 8'd200;
        tick();
        start8 = 1'b0;
        wait_finish(1'b0, 8, cyc, busy_cnt);
        check_eq("ign_fin_seen", 32'(fin8), 1);
        check_eq("ign_bcd", bcd_of(1'b0), to_bcd(37));
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (fin8) pulses++;
        end
        check_eq("ign_extra_pulses", pulses, 0);
        check_eq("ign_bcd_hold", bcd_of(1'b0), to_bcd(37));

        // Back-to-back: new start in the DONE cycle.
        drive_start(1'b0, 128);
        wait_finish(1'b0, 8, cyc, busy_cnt);
        check_eq("b2b_first_bcd", bcd_of(1'b0), to_bcd(128));
        drive_start(1'b0, 7);
        check_eq("b2b_busy", 32'(busy8), 1);
        check_eq("b2b_fin_low", 32'(fin8), 0);
        wait_finish(1'b0, 8, cyc, busy_cnt);
        check_eq("b2b_latency", cyc, 8);
        check_eq("b2b_second_bcd", bcd_of(1'b0), to_bcd(7));
        tick();

        // Reset mid-conversion aborts with no finished pulse.
        drive_start(1'b0, 250);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_busy", 32'(busy8), 0);
        check_eq("rst_bcd", bcd_of(1'b0), 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (fin8) pulses++;
            tick();
        end
        check_eq("rst_no_fin", pulses, 0);
        convert(1'b0, 250, "c250_after_rst");

        convert(1'b1, 65535, "w65535");
        convert(1'b1, 10000, "w10000");

        for (int i = 0; i < 20; i++) begin
            convert(1'b0, $urandom_range(0, 255), "rand8");
        end
        for (int i = 0; i < 8; i++) begin
            convert(1'b1, $urandom_range(0, 65535), "rand16");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_converter.md
Name: bcd_converter

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Sits directly downstream of the divider: it takes an N-bit quotient or remainder and produces packed decimal digits for the display/output path.
- Converts one bit per clock and completes in a fixed N cycles.
- Uses the same start/finished pulse handshake as the arithmetic units.

Parameters:
- N, 8, width of the binary input.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^N. Elaboration fails otherwise (N=8→3, N=16→5).

Ports:
- i_clock  input  1  rising-edge clock
- i_reset  input  1  synchronous, active-high reset
- i_start  input  1  request pulse; i_binary is sampled on the same edge
- i_binary  input  N  unsigned value to convert
- o_busy  output  1  high while a conversion is shifting
- o_finished  output  1  one-cycle pulse; o_bcd is valid from this cycle
- o_bcd  output  4*DIGITS  packed BCD, digit 0 in bits [3:0], most significant digit on top

Behaviour:
- Reset and clock: i_reset is synchronous, active-high; i_clock is the clock. Reset takes priority over everything.
- Reset values: state=IDLE, o_busy=0, o_finished=0, o_bcd=0, shift counter=0, scratch=0.
- States: IDLE, SHIFT, DONE (encoding from package).
- IDLE:
  - i_start=1 → load i_binary into the shift register, clear the BCD scratch, set counter=N, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each cycle:
  - For every 4-bit scratch digit ≥5, add 3 (combinational).
  - Shift {scratch, binary} left by 1, so the binary MSB enters scratch bit 0.
  - Decrement counter.
  - When counter reaches 1 on this edge, go to DONE and load o_bcd with the post-shift scratch.
- DONE (one cycle):
  - o_finished=1.
  - i_start=1 → starts a new conversion exactly as from IDLE (back-to-back throughput of N+1 cycles).
  - Otherwise go to IDLE.
- Timing, with i_start sampled on edge k:
  - o_busy is high from edge k+1 through edge k+N.
  - o_finished and the new o_bcd appear after edge k+N.
  - o_finished falls at edge k+N+1.
- o_bcd: holding register. It changes only at the SHIFT→DONE edge or on reset, and holds its value across later IDLE and SHIFT cycles.
- o_busy = (state==SHIFT). o_finished = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- i_start during SHIFT is ignored. No queueing; the caller must wait for o_finished.
- i_binary is don't-care except on the accepting edge.
- Reset mid-conversion: aborts immediately, o_bcd=0, no o_finished pulse.
- Add-3 applies to all DIGITS digits including the top one. Given the DIGITS constraint, the top digit never exceeds 9, so no carry out is needed and none is produced.
- Input 0 still takes the full N cycles; there is no early termination.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - BCD digit width constant 4;
  - a function computing the minimum DIGITS for N, used by the elaboration check.
- Sub-module bcd_digit_adjust:
  - combinational, 4-bit in and 4-bit out;
  - output = in+3 if in≥5, else in;
  - instantiated DIGITS times in a generate loop.

Test Plan:
- Reset, then i_start with i_binary=8'd255 (N=8) → o_busy high for 8 cycles; o_finished pulses after edge 8; o_bcd=12'h255.
- i_binary=0, then 8'd99, then 8'd100, run sequentially → o_bcd=12'h000, 12'h099, 12'h100; each o_finished pulse is exactly one cycle wide.
- Start 8'd37, assert i_start with 8'd200 at cycle 3 of SHIFT → second start ignored; o_bcd=12'h037; only one o_finished pulse.
- Start 8'd128, then assert i_start with 8'd7 in the DONE cycle → 12'h128 visible in that cycle; 12'h007 follows 8 cycles later (back-to-back).
- Start 8'd250, assert i_reset at cycle 4 → next cycle o_busy=0, o_bcd=0; no o_finished pulse; a later start converts correctly.
- N=16, DIGITS=5, i_binary=16'd65535 → o_finished after 16 shifts; o_bcd=20'h65535. Repeat with 16'd10000 → 20'h10000.
